tp_mem_pp: RTL and testbench

TP_MEM_PP -- requirements
Module: tp_mem_pp

---
 rtl/tp_mem_pp.sv | 119 +++++++++++
 tb/tb_tp_mem_pp.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tp_mem_pp.sv
// tp_mem_pp: N x N block transpose, rows in and registered columns out.
// Optional TP_MEM_PINGPONG_EN selects two banks for full throughput.
module tp_mem_pp #(
  parameter int BW = 8,
  parameter int N  = 8
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [N*BW-1:0] i_data,
  input  logic            i_enable,
  output logic            o_busy,
  output logic [N*BW-1:0] o_data,
  output logic            o_valid,
  output logic            o_last
);

  localparam int LW = $clog2(N);
  localparam logic [LW-1:0] LAST   = LW'(N - 1);
  localparam logic [LW-1:0] PENULT = LW'(N - 2);

`ifdef TP_MEM_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic {R_IDLE, R_OUT} rstate_e;

  rstate_e         state_q;
  logic [LW-1:0]   wr_row_q;
  logic [LW-1:0]   col_q;
  logic [LW-1:0]   nxt_col;
  logic [NB-1:0]   full_q;
  logic [NB-1:0]   full_d;
  logic            wr_bank;
  logic            rd_bank;
  logic            wr_fire;
  logic            wr_fill;
  logic            cont;
  logic            start;
  logic            emit;
  logic            last_emit;
  logic [N*BW-1:0] col_data;
  logic [BW-1:0]   mem_q [NB][N][N];

  assign wr_fire   = i_enable && !o_busy;
  assign wr_fill   = wr_fire && (wr_row_q == LAST);
  assign cont      = (state_q == R_OUT) && (col_q != LAST);
  assign start     = !cont && full_q[rd_bank];
  assign emit      = cont || start;
  assign last_emit = cont && (col_q == PENULT);
  assign nxt_col   = cont ? col_q + LW'(1) : '0;

`ifdef TP_MEM_PINGPONG_EN
  logic wr_bank_q;
  logic rd_bank_q;

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      if (wr_fill)   wr_bank_q <= ~wr_bank_q;
      if (last_emit) rd_bank_q <= ~rd_bank_q;
    end
  end

  assign wr_bank = wr_bank_q;
  assign rd_bank = rd_bank_q;
  assign o_busy  = 1'b0;
`else
  assign wr_bank = 1'b0;
  assign rd_bank = 1'b0;
  // The single bank is locked from fill until its last column is out.
  assign o_busy  = full_q[0];
`endif

  always_comb begin
    full_d = full_q;
    if (last_emit) full_d[rd_bank] = 1'b0;
    if (wr_fill)   full_d[wr_bank] = 1'b1;
  end

  always_comb begin
    col_data = '0;
    for (int r = 0; r < N; r++) begin
      col_data[(N-1-r)*BW +: BW] = mem_q[rd_bank][r][nxt_col];
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_fire) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_bank][wr_row_q][c] <= i_data[(N-1-c)*BW +: BW];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q  <= R_IDLE;
      col_q    <= '0;
      wr_row_q <= '0;
      full_q   <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
    end else begin
      full_q <= full_d;
      if (wr_fire) wr_row_q <= wr_row_q + LW'(1);
      state_q <= emit ? R_OUT : R_IDLE;
      col_q   <= nxt_col;
      o_valid <= emit;
      o_last  <= last_emit;
      o_data  <= emit ? col_data : '0;
    end
  end

endmodule

// File: tb/tb_tp_mem_pp.sv
// tb_tp_mem_pp: scoreboard bench for tp_mem_pp (N=8/BW=8 and N=4/BW=12).
// Expected columns are queued on block fill and popped on output cycles.
module tb_tp_mem_pp;

  logic        clk;
  logic        rst_n;
  logic        a_en;
  logic [63:0] a_data;
  logic        a_busy;
  logic [63:0] a_odata;
  logic        a_valid;
  logic        a_last;
  logic        b_en;
  logic [47:0] b_data;
  logic        b_busy;
  logic [47:0] b_odata;
  logic        b_valid;
  logic        b_last;

  tp_mem_pp #(.BW(8), .N(8)) u_a (
    .i_clk    (clk),
    .i_Reset  (rst_n),
    .i_data   (a_data),
    .i_enable (a_en),
    .o_busy   (a_busy),
    .o_data   (a_odata),
    .o_valid  (a_valid),
    .o_last   (a_last)
  );

  tp_mem_pp #(.BW(12), .N(4)) u_b (
    .i_clk    (clk),
    .i_Reset  (rst_n),
    .i_data   (b_data),
    .i_enable (b_en),
    .o_busy   (b_busy),
    .o_data   (b_odata),
    .o_valid  (b_valid),
    .o_last   (b_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mrow[8];
  int          mr;
  int          t;
  int          k_row;
  int          busy_until;
  bit          rnd;
  int          n_chk;
  int          n_err;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_row(int k);
    logic [63:0] v;
    for (int c = 0; c < 8; c++) v[(7-c)*8 +: 8] = 8'(8 * k + c);
    return v;
  endfunction

  function automatic logic [63:0] col_of(int c);
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[(7-r)*8 +: 8] = mrow[r][(7-c)*8 +: 8];
    return v;
  endfunction

  function automatic logic [47:0] b_row(int r);
    logic [47:0] v;
    for (int c = 0; c < 4; c++) v[(3-c)*12 +: 12] = 12'(256 * r + c);
    return v;
  endfunction

  function automatic logic [47:0] b_col(int c);
    logic [47:0] v;
    for (int r = 0; r < 4; r++) v[(3-r)*12 +: 12] = 12'(256 * r + c);
    return v;
  endfunction

  task automatic monitor();
    exp_t e;
    logic exp_busy;
`ifdef TP_MEM_PINGPONG_EN
    exp_busy = 1'b0;
`else
    exp_busy = (t < busy_until);
`endif
    if (sb.size() > 0 && sb[0].cyc == t) begin
      e = sb.pop_front();
      check($sformatf("valid@%0d", t), 64'(a_valid), 64'd1);
      check($sformatf("col@%0d", t), a_odata, e.data);
      check($sformatf("last@%0d", t), 64'(a_last), 64'(e.last));
    end else begin
      check($sformatf("idle_valid@%0d", t), 64'(a_valid), 64'd0);
      check($sformatf("idle_data@%0d", t), a_odata, 64'd0);
      check($sformatf("idle_last@%0d", t), 64'(a_last), 64'd0);
    end
    check($sformatf("busy@%0d", t), 64'(a_busy), 64'(exp_busy));
  endtask

  task automatic step(input bit en);
    logic [63:0] d;
    exp_t        e;
    d = rnd ? {$urandom, $urandom} : mk_row(k_row);
    a_en   = en;
    a_data = en ? d : {$urandom, $urandom};
    @(posedge clk);
    t++;
    if (en) k_row++;
    if (en && t > busy_until) begin
      mrow[mr] = d;
      mr++;
      if (mr == 8) begin
        mr = 0;
        for (int c = 0; c < 8; c++) begin
          e.cyc  = t + 1 + c;
          e.data = col_of(c);
          e.last = (c == 7);
          sb.push_back(e);
        end
`ifndef TP_MEM_PINGPONG_EN
        busy_until = t + 8;
`endif
      end
    end
    @(negedge clk);
    monitor();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    t = 0;
    k_row = 0;
    mr = 0;
    busy_until = 0;
    rnd = 1'b0;
    rst_n = 1'b1;
    a_en = 1'b0;
    a_data = '0;
    b_en = 1'b0;
    b_data = '0;

    #1 rst_n = 1'b0;
    #1;
    check("rst0_valid", 64'(a_valid), 64'd0);
    check("rst0_data", a_odata, 64'd0);
    check("rst0_last", 64'(a_last), 64'd0);
    check("rst0_busy", 64'(a_busy), 64'd0);
    check("rst0_b_valid", 64'(b_valid), 64'd0);
    a_en = 1'b1;
    a_data = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst1_valid", 64'(a_valid), 64'd0);
    rst_n = 1'b1;

    // Consecutive rows, lane = 8r+c.
    repeat (8) step(1'b1);
    repeat (12) step(1'b0);

    // Sustained enable: three blocks with ping-pong, drops without.
`ifdef TP_MEM_PINGPONG_EN
    repeat (24) step(1'b1);
`else
    repeat (32) step(1'b1);
`endif
    repeat (12) step(1'b0);

    // Rows every third cycle with random data.
    rnd = 1'b1;
    for (int i = 0; i < 24; i++) step(i % 3 == 0);
    repeat (12) step(1'b0);
    rnd = 1'b0;

    // Reset pulse mid-cycle while a block is being output.
    repeat (13) step(1'b1);
    check("pre_rst_valid", 64'(a_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_data", a_odata, 64'd0);
    check("rst_last", 64'(a_last), 64'd0);
    check("rst_busy", 64'(a_busy), 64'd0);
    sb.delete();
    mr = 0;
    busy_until = t;
    #1 rst_n = 1'b1;
    repeat (8) step(1'b1);
    repeat (12) step(1'b0);

    // N=4, BW=12 instance.
    for (int i = 0; i < 8; i++) begin
      b_en   = (i < 4);
      b_data = (i < 4) ? b_row(i) : 48'hABC_DEF_123_456;
      step(1'b0);
      if (i < 4) begin
        check($sformatf("b_idle_valid%0d", i), 64'(b_valid), 64'd0);
        check($sformatf("b_idle_data%0d", i), 64'(b_odata), 64'd0);
      end else begin
        check($sformatf("b_valid%0d", i - 4), 64'(b_valid), 64'd1);
        check($sformatf("b_col%0d", i - 4), 64'(b_odata),
              64'(b_col(i - 4)));
        check($sformatf("b_last%0d", i - 4), 64'(b_last),
              64'(i == 7));
      end
    end
    b_en = 1'b0;
    step(1'b0);
    check("b_after_valid", 64'(b_valid), 64'd0);
    check("b_after_data", 64'(b_odata), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
